// File: rtl/fp_downconvert_pipe_if.sv
// Stream bundle for the FP mantissa down-converter: input word with rounding mode,
// output word with per-result flags.
interface fp_downconvert_pipe_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       rnd_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_flags;

    modport master (
        output in_valid, in_data, rnd_mode, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, rnd_mode, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp_downconvert_pipe.sv
// Two-stage floating-point mantissa narrowing (same exponent width, no rebias) with
// truncate / half-up / nearest-even rounding, overflow policy and sticky status.
module fp_downconvert_pipe #(
    parameter int IN_EXP_W  = 4,
    parameter int IN_MAN_W  = 7,
    parameter int OUT_MAN_W = 3,
    parameter int SAT       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fp_downconvert_pipe_if.slave        bus,
    input  logic                        sts_clr,
    output logic [2:0]                  sts_flags,
    output logic [15:0]                 sts_count
);
    localparam int E     = IN_EXP_W;
    localparam int IM    = IN_MAN_W;
    localparam int OM    = OUT_MAN_W;
    localparam int D     = IM - OM;
    localparam int OUT_W = 1 + E + OM;

    localparam logic [E-1:0]  EXP_ONES    = '1;
    localparam logic [E-1:0]  EXP_MAX_FIN = EXP_ONES - E'(1);
    localparam logic [OM-1:0] MAN_ONES    = '1;
    localparam logic [OM-1:0] NAN_MAN     = ~(MAN_ONES >> 1);

    // ---------------- input decode ----------------
    logic          in_sign;
    logic [E-1:0]  in_exp;
    logic [IM-1:0] in_man;
    logic          guard, sticky, lsb, inc_next;

    assign in_sign = bus.in_data[IM+E];
    assign in_exp  = bus.in_data[IM +: E];
    assign in_man  = bus.in_data[IM-1:0];
    assign guard   = in_man[D-1];
    assign sticky  = |in_man[D-2:0];
    assign lsb     = in_man[D];

    always_comb begin
        inc_next = 1'b0;
        case (bus.rnd_mode)
            2'b00:   inc_next = 1'b0;
            2'b01:   inc_next = guard;
            default: inc_next = guard && (sticky || lsb);
        endcase
    end

    // ---------------- handshake ----------------
    logic s1_valid_reg, s2_valid_reg;
    logic s1_adv, s2_adv;

    assign s2_adv       = !s2_valid_reg || bus.out_ready;
    assign s1_adv       = !s1_valid_reg || s2_adv;
    assign bus.in_ready = s1_adv;

    // ---------------- stage 1: capture + rounding decision ----------------
    logic          s1_sign_reg, s1_inc_reg, s1_inexact_reg, s1_nan_reg, s1_inf_reg;
    logic [E-1:0]  s1_exp_reg;
    logic [OM-1:0] s1_man_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_exp_reg     <= '0;
            s1_man_reg     <= '0;
            s1_inc_reg     <= 1'b0;
            s1_inexact_reg <= 1'b0;
            s1_nan_reg     <= 1'b0;
            s1_inf_reg     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_reg    <= in_sign;
                s1_exp_reg     <= in_exp;
                s1_man_reg     <= in_man[IM-1:D];
                s1_inc_reg     <= inc_next;
                s1_inexact_reg <= guard || sticky;
                s1_nan_reg     <= (&in_exp) && (|in_man);
                s1_inf_reg     <= (&in_exp) && !(|in_man);
            end
        end
    end

    // ---------------- stage 2: result + flags ----------------
    // Exponent and mantissa are incremented as one integer so a mantissa carry
    // bumps the exponent (subnormal -> normal and normal -> overflow alike).
    logic [E+OM-1:0]  sum;
    logic [OUT_W-1:0] res_next, s2_data_reg;
    logic [2:0]       flg_next, s2_flags_reg;

    assign sum = {s1_exp_reg, s1_man_reg} + (E+OM)'(s1_inc_reg);

    always_comb begin
        res_next = {s1_sign_reg, sum};
        flg_next = {2'b00, s1_inexact_reg};
        if (s1_nan_reg) begin
            res_next = {s1_sign_reg, EXP_ONES, NAN_MAN};
            flg_next = 3'b100;
        end else if (s1_inf_reg) begin
            res_next = {s1_sign_reg, EXP_ONES, {OM{1'b0}}};
            flg_next = 3'b000;
        end else if (sum[OM +: E] == EXP_ONES) begin
            res_next = (SAT != 0) ? {s1_sign_reg, EXP_MAX_FIN, MAN_ONES}
                                  : {s1_sign_reg, EXP_ONES, {OM{1'b0}}};
            flg_next = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_flags_reg <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg  <= res_next;
                s2_flags_reg <= flg_next;
            end
        end
    end

    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = s2_data_reg;
    assign bus.out_flags = s2_flags_reg;

    // ---------------- status ----------------
    logic        xfer;
    logic [2:0]  sts_flags_reg, sts_flags_next;
    logic [15:0] sts_count_reg, sts_count_next;

    assign xfer = s2_valid_reg && bus.out_ready;

    // A clear in the same cycle as a transfer still records that transfer.
    always_comb begin
        sts_flags_next = sts_clr ? 3'b000 : sts_flags_reg;
        sts_count_next = sts_clr ? 16'h0000 : sts_count_reg;
        if (xfer) begin
            sts_flags_next = sts_flags_next | s2_flags_reg;
            if (sts_count_next != 16'hFFFF)
                sts_count_next = sts_count_next + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_flags_reg <= '0;
            sts_count_reg <= '0;
        end else begin
            sts_flags_reg <= sts_flags_next;
            sts_count_reg <= sts_count_next;
        end
    end

    assign sts_flags = sts_flags_reg;
    assign sts_count = sts_count_reg;
endmodule
